// File: rtl/cargador_entradas_pkg.sv
// Shared constants and state encoding for the entry-memory writer.
// ENTRY_BYTES/DEPTH/PTR_W size the memory.
// ENTRY_W is the packed entry width.
// CNT_W is the width of the per-entry byte counter.
package cargador_entradas_pkg;

    localparam int ENTRY_BYTES = 12;
    localparam int DEPTH       = 4;
    localparam int PTR_W       = 2;
    localparam int ENTRY_W     = 8 * ENTRY_BYTES;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        CARGA     = 2'd0,   // accepting header bytes
        ESCRITURA = 2'd1,   // committing the assembled entry to memory
        ARRANQUE  = 2'd2,   // one-cycle start pulse to the miner
        MINADO    = 2'd3    // miner running; loading held off until fin
    } estado_t;

endpackage

// File: rtl/ensamblador_bytes.sv
// Byte-to-entry assembler.
// Shifts each accepted byte into the low end of a 96-bit register, so the
// first byte of an entry ends up in the top byte. It counts bytes 0..11 and
// raises done combinationally on the transfer that carries the 12th byte.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   shift_en     a byte transfer happens on this edge
//   clear        drop the byte count (start of a new load)
//   byte_in      incoming byte
//   ens          assembled entry
//   done         this transfer completes an entry
module ensamblador_bytes
    import cargador_entradas_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clear,
    input  logic [7:0]         byte_in,
    output logic [ENTRY_W-1:0] ens,
    output logic               done
);

    logic [ENTRY_W-1:0] ens_q, ens_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        ens_d = ens_q;
        cnt_d = cnt_q;
        done  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (shift_en) begin
            ens_d = {ens_q[ENTRY_W-9:0], byte_in};
            if (cnt_q == CNT_W'(ENTRY_BYTES - 1)) begin
                cnt_d = '0;
                done  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ens_q <= '0;
            cnt_q <= '0;
        end else begin
            ens_q <= ens_d;
            cnt_q <= cnt_d;
        end
    end

    assign ens = ens_q;

endmodule

// File: rtl/cargador_entradas.sv
// Writer side of the miner's 96-bit entry memory.
// Header bytes arrive on a valid/ready stream and are packed into 96-bit
// entries. Up to DEPTH entries are stored. The block then pulses start and
// waits for fin before loading again.
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
// byte_ready depends only on state and reset, never on byte_valid.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   byte_in/valid/last/ready     byte stream; byte_last is honoured on byte 12 only
//   rd_ptr, entrada              registered read port, entrada = mem[rd_ptr]
//   num_entradas                 loaded entries minus one
//   start                        one-cycle launch pulse
//   fin                          miner done; re-enables loading
module cargador_entradas
    import cargador_entradas_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    input  logic               byte_last,
    output logic               byte_ready,
    input  logic [PTR_W-1:0]   rd_ptr,
    output logic [ENTRY_W-1:0] entrada,
    output logic [PTR_W-1:0]   num_entradas,
    output logic               start,
    input  logic               fin
);

    estado_t            estado_q, estado_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   num_q, num_d;
    logic               ult_q, ult_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [ENTRY_W-1:0] entrada_q, entrada_d;

    logic               ready;
    logic               shift_en;
    logic               clear_ens;
    logic               done;
    logic [ENTRY_W-1:0] ens;

    // Ready is gated by reset so the stream sees "not ready" while in reset.
    assign ready    = (estado_q == CARGA) && !reset;
    assign shift_en = byte_valid && ready;

    ensamblador_bytes u_ensamblador (
        .clk      (clk),
        .rst      (reset),
        .shift_en (shift_en),
        .clear    (clear_ens),
        .byte_in  (byte_in),
        .ens      (ens),
        .done     (done)
    );

    always_comb begin
        estado_d  = estado_q;
        wr_ptr_d  = wr_ptr_q;
        num_d     = num_q;
        ult_d     = ult_q;
        clear_ens = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        entrada_d = mem_q[rd_ptr];

        case (estado_q)
            CARGA: begin
                if (done) begin
                    ult_d    = byte_last;
                    estado_d = ESCRITURA;
                end
            end
            ESCRITURA: begin
                mem_d[wr_ptr_q] = ens;
                // The last slot forces launch; wr_ptr never wraps.
                if (ult_q || wr_ptr_q == PTR_W'(DEPTH - 1)) begin
                    num_d    = wr_ptr_q;
                    estado_d = ARRANQUE;
                end else begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    estado_d = CARGA;
                end
            end
            ARRANQUE: begin
                estado_d = MINADO;
            end
            MINADO: begin
                if (fin) begin
                    wr_ptr_d  = '0;
                    clear_ens = 1'b1;
                    estado_d  = CARGA;
                end
            end
            default: begin
                estado_d = CARGA;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= CARGA;
            wr_ptr_q  <= '0;
            num_q     <= '0;
            ult_q     <= 1'b0;
            entrada_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            estado_q  <= estado_d;
            wr_ptr_q  <= wr_ptr_d;
            num_q     <= num_d;
            ult_q     <= ult_d;
            entrada_q <= entrada_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign byte_ready   = ready;
    assign start        = (estado_q == ARRANQUE);
    assign num_entradas = num_q;
    assign entrada      = entrada_q;

endmodule

// File: tb/tb_cargador_entradas.sv
`timescale 1ns/1ps
module tb_cargador_entradas;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        byte_ready;
    logic [1:0]  rd_ptr;
    logic [95:0] entrada;
    logic [1:0]  num_entradas;
    logic        start;
    logic        fin;

    cargador_entradas dut (
        .clk          (clk),
        .reset        (reset),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .rd_ptr       (rd_ptr),
        .entrada      (entrada),
        .num_entradas (num_entradas),
        .start        (start),
        .fin          (fin)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [95:0] mem_m [4];
    int          num_m;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [95:0] pattern_entry(input int n);
        logic [95:0] v;
        v = '0;
        for (int i = 0; i < 12; i++) v[95-8*i -: 8] = 8'(16 * n + i);
        return v;
    endfunction

    function automatic logic [95:0] rand_entry();
        logic [95:0] v;
        v = {$urandom(), $urandom(), $urandom()};
        return v;
    endfunction

    // ---------------- driver tasks (all start and end at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        byte_last  = last;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) check_eq("ready_timeout", 96'(byte_ready), 96'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_in    = $urandom_range(0, 255);
    endtask

    // last_pos: 1..11 asserts byte_last on that byte (must be ignored), 0 = none.
    task automatic load_entry(input logic [95:0] val, input logic last12, input int last_pos, input int gap);
        for (int i = 0; i < 12; i++)
            send_byte(val[95-8*i -: 8], (i == 11) ? last12 : (i + 1 == last_pos), gap);
    endtask

    task automatic check_launch(input string tag, input int exp_num);
        check_eq({tag, "_start_early"}, 96'(start), 96'd0);
        @(negedge clk);
        check_eq({tag, "_start"}, 96'(start), 96'd1);
        check_eq({tag, "_num"}, 96'(num_entradas), 96'(exp_num));
        @(negedge clk);
        check_eq({tag, "_start_low"}, 96'(start), 96'd0);
        check_eq({tag, "_ready_held"}, 96'(byte_ready), 96'd0);
    endtask

    task automatic check_no_launch(input string tag);
        @(negedge clk);
        check_eq({tag, "_no_start"}, 96'(start), 96'd0);
        check_eq({tag, "_ready_back"}, 96'(byte_ready), 96'd1);
    endtask

    task automatic read_all(input string tag);
        for (int p = 0; p < 4; p++) begin
            rd_ptr = 2'(p);
            @(negedge clk);
            check_eq($sformatf("%s_rd%0d", tag, p), entrada, mem_m[p]);
        end
    endtask

    task automatic pulse_fin(input int cycles);
        fin = 1'b1;
        repeat (cycles) @(negedge clk);
        fin = 1'b0;
        check_eq("fin_ready", 96'(byte_ready), 96'd1);
        @(negedge clk);
        check_eq("fin_no_start", 96'(start), 96'd0);
    endtask

    // Load k entries; byte_last on the last one unless 'with_last' is clear.
    task automatic load_block(input string tag, input int k, input logic with_last, input int gap);
        logic [95:0] v;
        for (int e = 0; e < k; e++) begin
            v = rand_entry();
            load_entry(v, with_last && (e == k - 1), 0, gap);
            mem_m[e] = v;
        end
        num_m = k - 1;
        check_launch(tag, num_m);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [95:0] v;
        int k;
        reset = 1'b1; byte_in = '0; byte_valid = 1'b0; byte_last = 1'b0;
        rd_ptr = '0; fin = 1'b0;
        for (int i = 0; i < 4; i++) mem_m[i] = '0;
        num_m = 0;

        // 1. reset
        repeat (3) @(negedge clk);
        check_eq("rst_ready_in_reset", 96'(byte_ready), 96'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", 96'(byte_ready), 96'd1);
        check_eq("rst_start", 96'(start), 96'd0);
        check_eq("rst_num", 96'(num_entradas), 96'd0);
        read_all("rst");

        // 2. single entry with byte_last
        v = 96'h0102030405060708090A0B0C;
        load_entry(v, 1'b1, 0, 0);
        mem_m[0] = v;
        check_launch("single", 0);
        rd_ptr = 2'd0;
        @(negedge clk);
        check_eq("single_data", entrada, v);
        repeat (3) begin
            @(negedge clk);
            check_eq("single_ready_low", 96'(byte_ready), 96'd0);
        end
        pulse_fin(1);

        // 3. four entries, auto-launch
        for (int n = 1; n <= 4; n++) begin
            load_entry(pattern_entry(n), 1'b0, 0, 0);
            mem_m[n-1] = pattern_entry(n);
        end
        check_launch("four", 3);
        byte_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("four_no_5th", 96'(byte_ready), 96'd0);
        end
        byte_valid = 1'b0;
        read_all("four");

        // 5. reload after a 2-cycle fin
        pulse_fin(2);
        v = rand_entry();
        load_entry(v, 1'b1, 0, $urandom_range(0, 2));
        mem_m[0] = v;
        check_launch("reload", 0);
        read_all("reload");
        pulse_fin(1);

        // 4. gaps and ignored byte_last
        v = rand_entry();
        load_entry(v, 1'b0, 5, 1);
        mem_m[0] = v;
        check_no_launch("gap");
        v = rand_entry();
        load_entry(v, 1'b1, 0, 1);
        mem_m[1] = v;
        check_launch("gap", 1);
        read_all("gap");
        pulse_fin(1);

        // random blocks
        for (int r = 0; r < 4; r++) begin
            k = $urandom_range(1, 4);
            load_block($sformatf("rnd%0d", r), k, (k < 4) ? 1'b1 : 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2));
            read_all($sformatf("rnd%0d", r));
            pulse_fin($urandom_range(1, 3));
        end

        // 6. reset in the middle of a load
        v = rand_entry();
        for (int i = 0; i < 7; i++) send_byte(v[95-8*i -: 8], 1'b0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) mem_m[i] = '0;
        @(negedge clk);
        check_eq("midrst_num", 96'(num_entradas), 96'd0);
        check_eq("midrst_ready", 96'(byte_ready), 96'd1);
        read_all("midrst");
        v = rand_entry();
        load_entry(v, 1'b1, 0, 0);
        mem_m[0] = v;
        check_launch("midrst", 0);
        read_all("midrst_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
